// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - divider state encodings, EX handshake codes and sign helper
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  // A value is negated only for signed divides whose relevant sign bit is set.
  function automatic logic take_neg(input logic is_signed, input logic sign);
    return is_signed & sign;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring-division iteration on the {partial remainder, dividend} register
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  shift_reg,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  shift_next
);
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // The partial remainder plus the next dividend bit can reach WIDTH+1 bits.
  assign hi   = shift_reg[2*WIDTH:WIDTH];
  assign ge   = hi >= {1'b0, divisor};
  assign diff = hi[WIDTH-1:0] - divisor;

  always_comb begin
    shift_next = {shift_reg[2*WIDTH-1:0], 1'b0};
    if (ge) begin
      shift_next = {diff, shift_reg[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned divider for EX DIV/DIVU
// DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  localparam int SW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    shift_reg;
  logic [SW-1:0]    shift_next;
  logic [WIDTH-1:0] divisor;
  logic             sign1;
  logic             sign2;
  logic             signed_op;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             early;

  assign abs1 = take_neg(signed_div_i, opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = take_neg(signed_div_i, opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
  assign early = abs1 < abs2;
`else
  assign early = 1'b0;
`endif

  // The remainder takes the dividend's sign, the quotient the xor of both.
  assign quot_fix = take_neg(signed_op, sign1 ^ sign2) ? -shift_reg[WIDTH-1:0]
                                                       : shift_reg[WIDTH-1:0];
  assign rem_fix  = take_neg(signed_op, sign1) ? -shift_reg[SW-1:WIDTH+1]
                                               : shift_reg[SW-1:WIDTH+1];

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .shift_reg  (shift_reg),
    .divisor    (divisor),
    .shift_next (shift_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DivFree;
      cnt       <= '0;
      shift_reg <= '0;
      divisor   <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      signed_op <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else if (early) begin
              state    <= DivEnd;
              result_o <= {opdata1_i, {WIDTH{1'b0}}};
            end else begin
              state     <= DivOn;
              cnt       <= '0;
              shift_reg <= {{WIDTH{1'b0}}, abs1, 1'b0};
              divisor   <= abs2;
              sign1     <= opdata1_i[WIDTH-1];
              sign2     <= opdata2_i[WIDTH-1];
              signed_op <= signed_div_i;
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt != LastCnt) begin
            shift_reg <= shift_next;
            cnt       <= cnt + 1'b1;
          end else begin
            state    <= DivEnd;
            cnt      <= '0;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule
